// File: rtl/bus_master_lsu_if.sv
// Core request/response handshake plus the address/mode half of the shared
// data bus. The tri-state data lines stay a plain inout port on the master.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; resp_valid is a single-cycle pulse with
// resp_rdata/resp_error valid in that cycle.
interface bus_master_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output data_bus_addr, data_bus_mode
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  data_bus_addr, data_bus_mode
    );
endinterface

// File: rtl/bus_master_lsu.sv
// Load/store initiator for the shared memory-mapped data bus.
// Sub-word stores are done as read-modify-write because responders latch
// full 32-bit words. Optional macro BUS_MASTER_MISALIGN_TRAP_EN turns
// misaligned / size-11 requests into error responses with no bus cycle.
module bus_master_lsu #(
    parameter int unsigned READ_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    bus_master_lsu_if.master  bus,
    inout  wire  [31:0]       data_bus_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_wdata;
    logic [3:0]  wait_cnt;
    logic [31:0] wr_word;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic        req_err;
    logic        req_sub;
    logic        read_last;

    // Lane extraction followed by sign/zero extension.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lo,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [15:0] h;
        sh = word >> {lo, 3'b000};
        h  = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_ext = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_ext = word;
        endcase
    endfunction

    // Insert store data into the captured word, leaving other lanes intact.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (size == 2'b00)
            m[{lo, 3'b000} +: 8] = wd[7:0];
        else
            m[{lo[1], 4'b0000} +: 16] = wd;
        merge = m;
    endfunction

`ifdef BUS_MASTER_MISALIGN_TRAP_EN
    assign req_err = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    assign req_sub   = bus.req_write && (bus.req_size == 2'b00 || bus.req_size == 2'b01);
    assign read_last = (wait_cnt == 4'(READ_WAIT));
    assign dbg_state = state;

    // Master drives data only during WRITE; released the cycle mode leaves 10.
    assign data_bus_data = (state == S_WRITE) ? wr_word : 32'bz;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and bus/handshake outputs.
    always_comb begin
        state_nxt          = state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.data_bus_mode  = 2'b00;
        bus.data_bus_addr  = {r_addr[31:2], 2'b00};
        bus.resp_rdata     = resp_rdata_q;
        bus.resp_error     = resp_error_q;
        case (state)
            S_IDLE: begin
                bus.req_ready     = 1'b1;
                bus.data_bus_addr = 32'h0;
                if (bus.req_valid) begin
                    if (req_err)                         state_nxt = S_RESP;
                    else if (!bus.req_write || req_sub) state_nxt = S_READ;
                    else                                 state_nxt = S_WRITE;
                end
            end
            S_READ: begin
                bus.data_bus_mode = 2'b01;
                if (read_last) state_nxt = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.data_bus_mode = 2'b10;
                state_nxt         = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, read-data capture/merge and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_addr       <= 32'h0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_wdata      <= 16'h0;
            wait_cnt     <= 4'd0;
            wr_word      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write    <= bus.req_write;
                        r_addr     <= bus.req_addr;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata[15:0];
                        wr_word    <= bus.req_wdata;
                        wait_cnt   <= 4'd0;
                        if (req_err) begin
                            resp_rdata_q <= 32'h0;
                            resp_error_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (read_last) begin
                        if (r_write) begin
                            wr_word <= merge(data_bus_data, r_addr[1:0], r_size, r_wdata);
                        end else begin
                            resp_rdata_q <= load_ext(data_bus_data, r_addr[1:0], r_size, r_unsigned);
                            resp_error_q <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_WRITE: begin
                    resp_rdata_q <= 32'h0;
                    resp_error_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_lsu.sv
// Directed bench for bus_master_lsu. Three instances share the request
// fields: READ_WAIT = 0, 2 and 3. A small responder model backs the bus:
// LED port at 0x40F0 plus data words at 0x1000 and 0x2000.
module tb_bus_master_lsu;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  req_valid_a;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    wire [2:0]       req_ready_a;
    wire [2:0]       resp_valid_a;
    wire [2:0]       resp_error_a;
    wire [2:0][31:0] resp_rdata_a;
    wire [2:0][31:0] addr_a;
    wire [2:0][31:0] wdata_a;
    wire [2:0][1:0]  mode_a;
    wire [2:0][1:0]  state_a;

    logic [7:0]  leds_out  = 8'h00;
    logic [31:0] word_1000 = 32'h8000FF7F;
    logic [31:0] word_2000 = 32'h11223344;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h000040F0: mem_rd = {24'h0, leds_out};
            32'h00001000: mem_rd = word_1000;
            32'h00002000: mem_rd = word_2000;
            default:      mem_rd = 32'h0;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned RW = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        bus_master_lsu_if bif();
        wire [31:0] bus_w;

        assign bif.req_valid    = req_valid_a[g];
        assign bif.req_write    = req_write;
        assign bif.req_addr     = req_addr;
        assign bif.req_size     = req_size;
        assign bif.req_unsigned = req_unsigned;
        assign bif.req_wdata    = req_wdata;
        assign req_ready_a[g]   = bif.req_ready;
        assign resp_valid_a[g]  = bif.resp_valid;
        assign resp_error_a[g]  = bif.resp_error;
        assign resp_rdata_a[g]  = bif.resp_rdata;
        assign addr_a[g]        = bif.data_bus_addr;
        assign mode_a[g]        = bif.data_bus_mode;
        assign bus_w            = (bif.data_bus_mode == 2'b01) ? mem_rd(bif.data_bus_addr) : 32'bz;
        assign wdata_a[g]       = bus_w;

        bus_master_lsu #(.READ_WAIT(RW)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .bus           (bif.master),
            .data_bus_data (bus_w),
            .dbg_state     (state_a[g])
        );
    end

    // Responder: latch full words on the edge ending a WRITE cycle.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mode_a[g] == 2'b10) begin
                case (addr_a[g])
                    32'h000040F0: leds_out  <= wdata_a[g][7:0];
                    32'h00001000: word_1000 <= wdata_a[g];
                    32'h00002000: word_2000 <= wdata_a[g];
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request on instance s and observe it until resp_valid.
    // lat counts cycles after the acceptance edge; returns at the negedge of
    // the response cycle. With hold set, req_valid is left asserted.
    task automatic do_req(input int s, input logic wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                          input bit hold, output int lat, output int rdc,
                          output logic [31:0] rdata, output logic err,
                          output logic [31:0] wa, output logic [31:0] wdv);
        int ready_hi;
        lat = 0; rdc = 0; rdata = 32'h0; err = 1'b0; wa = 32'h0; wdv = 32'h0;
        ready_hi = 0;
        @(negedge clk);
        req_write = wr; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid_a[s] = 1'b1;
        check("req_ready_idle", {31'h0, req_ready_a[s]}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid_a[s] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (req_ready_a[s]) ready_hi++;
            if (mode_a[s] == 2'b01) rdc++;
            if (mode_a[s] == 2'b10) begin
                wa  = addr_a[s];
                wdv = wdata_a[s];
            end
            if (resp_valid_a[s]) begin
                lat   = c;
                rdata = resp_rdata_a[s];
                err   = resp_error_a[s];
                break;
            end
            @(negedge clk);
        end
        check("resp_timeout", {31'h0, lat != 0}, 32'h1);
        check("req_ready_busy", ready_hi, 32'h0);
    endtask

    int          lat, rdc, cnt;
    logic [31:0] rd, wa, wdv;
    logic        er;

    initial begin
        reset = 1'b1;
        req_valid_a = 3'b000;
        req_write = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready",  {31'h0, req_ready_a[0]}, 32'h1);
        check("rst_mode",   {30'h0, mode_a[0]}, 32'h0);
        check("rst_addr",   addr_a[0], 32'h0);
        check("rst_resp",   {31'h0, resp_valid_a[0]}, 32'h0);
        check("rst_rdata",  resp_rdata_a[0], 32'h0);
        check("rst_err",    {31'h0, resp_error_a[0]}, 32'h0);
        check("rst_state",  {30'h0, state_a[0]}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Word store to the LED port, then read it back
        do_req(0, 1'b1, 32'h40F0, 2'b10, 1'b0, 32'h000000A5, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("wst_lat",    lat, 32'd2);
        check("wst_nread",  rdc, 32'd0);
        check("wst_addr",   wa, 32'h40F0);
        check("wst_data",   wdv, 32'h000000A5);
        check("wst_rdata",  rd, 32'h0);
        check("wst_leds",   {24'h0, leds_out}, 32'hA5);
        do_req(0, 1'b0, 32'h40F0, 2'b10, 1'b0, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("wld_lat",    lat, 32'd2);
        check("wld_rdata",  rd, 32'h000000A5);

        // Sub-word loads of 0x8000FF7F
        do_req(0, 1'b0, 32'h1000, 2'b00, 1'b0, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("lb_1000_s",  rd, 32'h0000007F);
        do_req(0, 1'b0, 32'h1001, 2'b00, 1'b0, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("lb_1001_s",  rd, 32'hFFFFFFFF);
        do_req(0, 1'b0, 32'h1003, 2'b00, 1'b1, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("lb_1003_u",  rd, 32'h00000080);
        do_req(0, 1'b0, 32'h1002, 2'b01, 1'b0, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("lh_1002_s",  rd, 32'hFFFF8000);
        do_req(0, 1'b0, 32'h1000, 2'b01, 1'b1, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("lh_1000_u",  rd, 32'h0000FF7F);

        // Read-modify-write sub-word stores on 0x11223344
        do_req(0, 1'b1, 32'h2002, 2'b00, 1'b0, 32'h123456AB, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("sb_lat",     lat, 32'd3);
        check("sb_nread",   rdc, 32'd1);
        check("sb_addr",    wa, 32'h2000);
        check("sb_data",    wdv, 32'h11AB3344);
        check("sb_rdata",   rd, 32'h0);
        do_req(0, 1'b1, 32'h2000, 2'b01, 1'b0, 32'h5555BEEF, 1'b0, lat, rdc, rd, er, wa, wdv);
        check("sh_lat",     lat, 32'd3);
        check("sh_data",    wdv, 32'h11ABBEEF);
        check("sh_mem",     word_2000, 32'h11ABBEEF);

        // Word load at 0x1002: trap or aligned-down read
        do_req(0, 1'b0, 32'h1002, 2'b10, 1'b0, 32'h0, 1'b0, lat, rdc, rd, er, wa, wdv);
`ifdef BUS_MASTER_MISALIGN_TRAP_EN
        check("mis_lat",    lat, 32'd1);
        check("mis_nread",  rdc, 32'd0);
        check("mis_err",    {31'h0, er}, 32'h1);
        check("mis_rdata",  rd, 32'h0);
`else
        check("mis_lat",    lat, 32'd2);
        check("mis_nread",  rdc, 32'd1);
        check("mis_err",    {31'h0, er}, 32'h0);
        check("mis_rdata",  rd, 32'h8000FF7F);
`endif

        // READ_WAIT=2 word load with req_valid held high
        do_req(1, 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 1'b1, lat, rdc, rd, er, wa, wdv);
        check("rw2_lat",    lat, 32'd4);
        check("rw2_nread",  rdc, 32'd3);
        check("rw2_rdata",  rd, 32'h8000FF7F);
        @(negedge clk);
        check("rw2_idle_ready", {31'h0, req_ready_a[1]}, 32'h1);
        @(negedge clk);
        check("rw2_reaccept", {30'h0, mode_a[1]}, 32'h1);
        req_valid_a[1] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10 && cnt == 0; c++) begin
            @(negedge clk);
            if (resp_valid_a[1]) cnt = c + 2;
        end
        check("rw2_second_lat", cnt, 32'd4);

        // READ_WAIT=3 load aborted by reset in the second wait cycle
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h1000; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid_a[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a[2] = 1'b0;
        check("abort_mode_c1", {30'h0, mode_a[2]}, 32'h1);
        repeat (2) @(negedge clk);
        check("abort_mode_c3", {30'h0, mode_a[2]}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort_mode",  {30'h0, mode_a[2]}, 32'h0);
        check("abort_addr",  addr_a[2], 32'h0);
        check("abort_state", {30'h0, state_a[2]}, 32'h0);
        check("abort_ready", {31'h0, req_ready_a[2]}, 32'h1);
        check("abort_resp",  {31'h0, resp_valid_a[2]}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid_a[2] || mode_a[2] != 2'b00) cnt++;
        end
        check("abort_quiet", cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
